// File: rtl/regfile_pkg.sv
// Shared types, default parameters and helpers for the multi-port register file.
package regfile_pkg;

    // Clear-sequencer states: sweeping zeros through the array, or normal operation.
    typedef enum logic {
        RF_CLEAR,
        RF_IDLE
    } rf_state_e;

    // Default geometry of the register file.
    localparam int unsigned DefXlen    = 32;
    localparam int unsigned DefNregs   = 32;
    localparam int unsigned DefNrd     = 2;
    localparam int unsigned DefNwr     = 1;
    localparam bit          DefBypass  = 1'b0;
    localparam bit          DefZeroReg = 1'b1;

    // First register touched by the clear sweep; a hardwired-zero register needs no clearing.
    function automatic int unsigned first_idx(input bit zero_reg);
        return zero_reg ? 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks an index from the first clearable register up to NREGS-1,
// asserting a zero-write each cycle; runs after reset release and on request.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS    = DefNregs,
    parameter bit          ZERO_REG = DefZeroReg,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear_req,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_idx
);

    localparam logic [AW-1:0] FirstIdx = AW'(first_idx(ZERO_REG));
    localparam logic [AW-1:0] LastIdx  = AW'(NREGS - 1);

    rf_state_e     r_state;
    rf_state_e     w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;

    // State and index registers; reset restarts the sweep from the first index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RF_CLEAR;
            r_idx   <= FirstIdx;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: the edge writing LastIdx ends the sweep, the index never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            RF_CLEAR: begin
                // Requests arriving mid-sweep are dropped, not queued.
                if (r_idx == LastIdx) begin
                    w_state_nxt = RF_IDLE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            RF_IDLE: begin
                if (i_clear_req) begin
                    w_state_nxt = RF_CLEAR;
                    w_idx_nxt   = FirstIdx;
                end
            end
        endcase
    end

    assign o_busy    = (r_state == RF_CLEAR);
    assign o_clr_we  = (r_state == RF_CLEAR);
    assign o_clr_idx = r_idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NWR prioritised write ports, NRD combinational read
// ports, optional same-cycle write bypass, optional hardwired-zero register 0, and a
// sequenced hardware clear in place of a storage reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = DefXlen,
    parameter int unsigned NREGS    = DefNregs,
    parameter int unsigned NRD      = DefNrd,
    parameter int unsigned NWR      = DefNwr,
    parameter bit          BYPASS   = DefBypass,
    parameter bit          ZERO_REG = DefZeroReg,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NRD*AW-1:0]   i_raddr,
    output logic [NRD*XLEN-1:0] o_rdata,
    input  logic [NWR-1:0]      i_wen,
    input  logic [NWR*AW-1:0]   i_waddr,
    input  logic [NWR*XLEN-1:0] i_wdata,
    input  logic                i_clear_req,
    output logic                o_busy
);

    logic [XLEN-1:0] r_regs [NREGS];

    logic [AW-1:0]   w_raddr [NRD];
    logic [XLEN-1:0] w_rd    [NRD];
    logic [AW-1:0]   w_waddr [NWR];
    logic [XLEN-1:0] w_wdata [NWR];

    logic          w_busy;
    logic          w_clr_we;
    logic [AW-1:0] w_clr_idx;
    logic          w_wr_ok;

    regfile_clr_seq #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_clr_seq (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear_req (i_clear_req),
        .o_busy      (w_busy),
        .o_clr_we    (w_clr_we),
        .o_clr_idx   (w_clr_idx)
    );

    for (genvar g = 0; g < NRD; g++) begin : g_rd_port
        assign w_raddr[g]                 = i_raddr[g*AW +: AW];
        assign o_rdata[g*XLEN +: XLEN]    = w_rd[g];
    end

    for (genvar g = 0; g < NWR; g++) begin : g_wr_port
        assign w_waddr[g] = i_waddr[g*AW +: AW];
        assign w_wdata[g] = i_wdata[g*XLEN +: XLEN];
    end

    // A clear request in idle wins over same-cycle writes.
    assign w_wr_ok = !w_busy && !i_clear_req;
    assign o_busy  = w_busy;

    // Storage update: clear sweep, else port writes in ascending order so the highest port wins.
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_regs[w_clr_idx] <= '0;
        end else if (w_wr_ok) begin
            for (int p = 0; p < NWR; p++) begin
                if (i_wen[p] && !(ZERO_REG && (w_waddr[p] == '0))) begin
                    r_regs[w_waddr[p]] <= w_wdata[p];
                end
            end
        end
    end

    // Read muxing: stored value, overridden by bypass, then by zero register, then by busy.
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            w_rd[r] = r_regs[w_raddr[r]];
            if (BYPASS) begin
                for (int p = 0; p < NWR; p++) begin
                    if (i_wen[p] && (w_waddr[p] == w_raddr[r])) begin
                        w_rd[r] = w_wdata[p];
                    end
                end
            end
            if (ZERO_REG && (w_raddr[r] == '0)) begin
                w_rd[r] = '0;
            end
            if (w_busy) begin
                w_rd[r] = '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances share stimulus (A: bypass on, zero reg on;
// B: bypass off, zero reg off), both with two write ports. A behavioural model tracks
// contents and remaining busy cycles; directed steps add literal expectations.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_req;
    logic [NWR-1:0]  wen;
    logic [AW-1:0]   ra [NRD];
    logic [AW-1:0]   wa [NWR];
    logic [XLEN-1:0] wd [NWR];

    logic [NRD*AW-1:0]   raddr;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD*XLEN-1:0] rdata_a;
    logic [NRD*XLEN-1:0] rdata_b;
    logic                busy_a;
    logic                busy_b;

    assign raddr = {ra[1], ra[0]};
    assign waddr = {wa[1], wa[0]};
    assign wdata = {wd[1], wd[0]};

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata_a), .i_wen(wen),
        .i_waddr(waddr), .i_wdata(wdata), .i_clear_req(clear_req), .o_busy(busy_a)
    );

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0), .ZERO_REG(1'b0)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata_b), .i_wen(wen),
        .i_waddr(waddr), .i_wdata(wdata), .i_clear_req(clear_req), .o_busy(busy_b)
    );

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_regs [2][NREGS];
    int              m_left [2];   // edges still needed before the instance is usable

    function automatic bit byp(input int d);
        return d == 0;
    endfunction

    function automatic bit zr(input int d);
        return d == 0;
    endfunction

    function automatic int clr_len(input int d);
        return zr(d) ? NREGS - 1 : NREGS;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_left[d] <= clr_len(d);
            end else if (m_left[d] > 0) begin
                m_left[d] <= m_left[d] - 1;
                if (m_left[d] == 1) begin
                    for (int i = 0; i < NREGS; i++) m_regs[d][i] <= '0;
                end
            end else if (clear_req) begin
                m_left[d] <= clr_len(d);
            end else begin
                for (int p = 0; p < NWR; p++) begin
                    if (wen[p] && !(zr(d) && wa[p] == 0)) m_regs[d][wa[p]] <= wd[p];
                end
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(input int d, input int r);
        logic [XLEN-1:0] v;
        if (m_left[d] > 0) return '0;
        if (zr(d) && ra[r] == 0) return '0;
        v = m_regs[d][ra[r]];
        if (byp(d)) begin
            for (int p = 0; p < NWR; p++) if (wen[p] && wa[p] == ra[r]) v = wd[p];
        end
        return v;
    endfunction

    function automatic logic [XLEN-1:0] dut_rd(input int d, input int r);
        return (d == 0) ? rdata_a[r*XLEN +: XLEN] : rdata_b[r*XLEN +: XLEN];
    endfunction

    // ---------------- compare process ----------------
    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] exp;
    } lit_t;
    lit_t lit_q [$];

    int n_checks;
    int n_fail;

    always @(negedge clk) begin
        lit_t e;
        logic [31:0] g;
        logic [31:0] x;
        while (lit_q.size() > 0) begin
            e = lit_q.pop_front();
            n_checks++;
            if (e.got !== e.exp) begin
                n_fail++;
                $display("FAIL %s got=%h exp=%h t=%0t", e.name, e.got, e.exp, $time);
            end
        end
        for (int d = 0; d < 2; d++) begin
            g = {31'b0, (d == 0) ? busy_a : busy_b};
            x = {31'b0, m_left[d] > 0};
            n_checks++;
            if (g !== x) begin
                n_fail++;
                $display("FAIL model_busy_%0d got=%h exp=%h t=%0t", d, g, x, $time);
            end
            for (int r = 0; r < NRD; r++) begin
                g = dut_rd(d, r);
                x = exp_rd(d, r);
                n_checks++;
                if (g !== x) begin
                    n_fail++;
                    $display("FAIL model_rdata_%0d_%0d addr=%0d got=%h exp=%h t=%0t",
                             d, r, ra[r], g, x, $time);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        lit_t e;
        e.name = name;
        e.got  = got;
        e.exp  = exp;
        lit_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until each instance drops busy; -1 marks an expired bound.
    task automatic wait_clear(input int start, output int ca, output int cb);
        int n;
        n  = start;
        ca = -1;
        cb = -1;
        for (int k = 0; k < 200; k++) begin
            if (ca < 0 && !busy_a) ca = n;
            if (cb < 0 && !busy_b) cb = n;
            if (ca >= 0 && cb >= 0) break;
            tick();
            n++;
        end
    endtask

    initial begin
        int ca;
        int cb;
        int n;
        clear_req = 1'b0;
        wen       = '0;
        ra[0] = 5'd5; ra[1] = 5'd0;
        wa[0] = '0;   wa[1] = '0;
        wd[0] = '0;   wd[1] = '0;

        repeat (3) tick();
        lit("rst_busy_a", {31'b0, busy_a}, 32'd1);
        lit("rst_busy_b", {31'b0, busy_b}, 32'd1);
        lit("rst_rdata_b", rdata_b[31:0], 32'h0);

        // Reset release: sweep length depends on the zero register.
        rst_n = 1'b1;
        wait_clear(0, ca, cb);
        lit("rel_edges_a", ca, 32'd31);
        lit("rel_edges_b", cb, 32'd32);

        // Both ports write address 5: port 1 wins.
        wen = 2'b11; wa[0] = 5'd5; wa[1] = 5'd5;
        wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222;
        ra[0] = 5'd9; ra[1] = 5'd9;
        tick();
        wen = '0; ra[0] = 5'd5;
        #1;
        lit("prio_a", rdata_a[31:0], 32'h2222_2222);
        lit("prio_b", rdata_b[31:0], 32'h2222_2222);

        // Same-cycle read of a write: bypass forwards, no bypass returns old value.
        wen = 2'b01; wa[0] = 5'd7; wd[0] = 32'hDEAD_BEEF; ra[0] = 5'd7; ra[1] = 5'd5;
        #1;
        lit("byp_same_a", rdata_a[31:0], 32'hDEAD_BEEF);
        lit("byp_same_b", rdata_b[31:0], 32'h0);
        tick();
        wen = '0;
        #1;
        lit("byp_next_a", rdata_a[31:0], 32'hDEAD_BEEF);
        lit("byp_next_b", rdata_b[31:0], 32'hDEAD_BEEF);

        // Write to address 0 through port 1 with a matching read.
        wen = 2'b10; wa[1] = 5'd0; wd[1] = 32'hFFFF_FFFF; ra[1] = 5'd0;
        #1;
        lit("zero_same_a", rdata_a[63:32], 32'h0);
        lit("zero_same_b", rdata_b[63:32], 32'h0);
        tick();
        wen = '0;
        #1;
        lit("zero_next_a", rdata_a[63:32], 32'h0);
        lit("zero_next_b", rdata_b[63:32], 32'hFFFF_FFFF);

        // Load addresses 1..31 with distinct values, alternating ports.
        for (int i = 1; i < NREGS; i++) begin
            wen   = (i % 2 == 1) ? 2'b01 : 2'b10;
            wa[0] = AW'(i); wa[1] = AW'(i);
            wd[0] = i * 32'h0101_0101; wd[1] = i * 32'h0101_0101;
            ra[0] = AW'(i); ra[1] = AW'(i - 1);
            tick();
        end
        wen = '0; ra[0] = 5'd3; ra[1] = 5'd31;
        #1;
        lit("load3_a", rdata_a[31:0], 32'h0303_0303);
        lit("load31_b", rdata_b[63:32], 32'h1F1F_1F1F);

        // Clear request with a same-cycle write that must be dropped.
        ra[0] = 5'd10; ra[1] = 5'd9;
        wen = 2'b01; wa[0] = 5'd3; wd[0] = 32'h55; clear_req = 1'b1;
        tick();
        clear_req = 1'b0; wen = '0; n = 1;
        repeat (4) begin tick(); n++; end
        clear_req = 1'b1; wen = 2'b01; wa[0] = 5'd4; wd[0] = 32'h77;
        tick();
        n++;
        clear_req = 1'b0; wen = '0;
        wait_clear(n, ca, cb);
        lit("req_edges_a", ca, 32'd32);
        lit("req_edges_b", cb, 32'd33);
        ra[0] = 5'd3; ra[1] = 5'd4;
        #1;
        lit("req_drop3_a", rdata_a[31:0], 32'h0);
        lit("req_drop4_b", rdata_b[63:32], 32'h0);
        for (int a = 0; a < NREGS; a += 2) begin
            ra[0] = AW'(a); ra[1] = AW'(a + 1);
            tick();
        end

        // Fill junk, then reset in idle and again mid-sweep at index 10 of instance A.
        for (int i = 0; i < NREGS; i++) begin
            wen = 2'b01; wa[0] = AW'(i); wd[0] = 32'hC0DE_0000 + i;
            tick();
        end
        wen = '0;
        rst_n = 1'b0;
        #1;
        lit("idle_rst_busy_a", {31'b0, busy_a}, 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        lit("mid_rst_busy_a", {31'b0, busy_a}, 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_clear(0, ca, cb);
        lit("mid_rel_edges_a", ca, 32'd31);
        lit("mid_rel_edges_b", cb, 32'd32);
        ra[0] = 5'd2; ra[1] = 5'd0;
        #1;
        lit("junk2_a", rdata_a[31:0], 32'h0);
        lit("junk0_b", rdata_b[63:32], 32'h0);
        for (int a = 0; a < NREGS; a += 2) begin
            ra[0] = AW'(a); ra[1] = AW'(a + 1);
            tick();
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
